// File: rtl/mips_stage_mem_pkg.sv
// Shared types for the MIPS memory-access stage: access size, FSM state,
// control field layout and the EX->MEM / MEM->WB pipeline bundles.
package mips_stage_mem_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // An all-zero control word is a bubble: no memory op, no writeback.
    typedef struct packed {
        logic      reg_write;
        logic      mem_to_reg;
        logic      mem_read;
        logic      mem_write;
        mem_size_e mem_size;
        logic      mem_signed;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_addr;
        ctrl_t       ctrl;
        logic [31:0] reg_port2;
        logic [31:0] alu_result;
    } ex_mem_t;

    typedef struct packed {
        logic [31:0] instruction;
        logic [31:0] pc_addr;
        ctrl_t       ctrl;
        logic [31:0] alu_result;
        logic [31:0] mem_data;
    } mem_wb_t;

    localparam mem_wb_t MEM_WB_BUBBLE = '0;

    function automatic logic is_mem_op(input logic mem_read, input logic mem_write);
        return mem_read | mem_write;
    endfunction

endpackage

// File: rtl/mips_stage_mem_if.sv
// Single-port data memory bus: request/ready handshake, the stage is master.
interface mips_stage_mem_if;
    logic        mem_req;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [3:0]  mem_byte_en;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_req, mem_write, mem_addr, mem_byte_en, mem_wdata,
        input  mem_rdata, mem_ready
    );

    modport slave (
        input  mem_req, mem_write, mem_addr, mem_byte_en, mem_wdata,
        output mem_rdata, mem_ready
    );
endinterface

// File: rtl/mips_stage_mem_align.sv
// Sub-word lane logic: byte enables, store replication, load extend, misalignment.
// Latency: purely combinational.
// Backpressure: none, follows its inputs.
module mips_stage_mem_align
    import mips_stage_mem_pkg::*;
(
    input  logic        mem_read,
    input  mem_size_e   mem_size,
    input  logic        mem_signed,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] load_raw,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [7:0]  lane;
    logic [15:0] half;
    logic [31:0] extended;

    always_comb begin
        lane = load_raw[7:0];
        case (addr_lo)
            2'd1:    lane = load_raw[15:8];
            2'd2:    lane = load_raw[23:16];
            2'd3:    lane = load_raw[31:24];
            default: lane = load_raw[7:0];
        endcase
        half = addr_lo[1] ? load_raw[31:16] : load_raw[15:0];
    end

    always_comb begin
        byte_en    = 4'b1111;
        wdata      = store_data;
        extended   = load_raw;
        misaligned = 1'b0;
        case (mem_size)
            MEM_BYTE: begin
                byte_en  = 4'b0001 << addr_lo;
                wdata    = {4{store_data[7:0]}};
                extended = {{24{mem_signed & lane[7]}}, lane};
            end
            MEM_HALF: begin
                byte_en    = 4'b0011 << addr_lo;
                wdata      = {2{store_data[15:0]}};
                extended   = {{16{mem_signed & half[15]}}, half};
                misaligned = addr_lo[0];
            end
            default: begin
                misaligned = |addr_lo;
            end
        endcase
        load_data = mem_read ? extended : 32'd0;
    end

endmodule

// File: rtl/mips_stage_mem.sv
// MEM stage: issues loads/stores to data memory, stalls upstream while waiting.
// Latency: 1 cycle from access completion to pipe_mem_wb (DELAYED=1), else 0.
// Backpressure: stall high while memory has not answered; timeout after WAIT_LIMIT.
module mips_stage_mem
    import mips_stage_mem_pkg::*;
#(
    parameter bit DELAYED    = 1'b1,
    parameter int WAIT_LIMIT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  ex_mem_t           pipe_ex_mem,
    output mem_wb_t           pipe_mem_wb,
    output logic              stall,
    output logic              addr_error,
    output logic              bus_error,
    mips_stage_mem_if.master  mem_bus
);

    localparam logic [7:0] LIMIT = 8'(WAIT_LIMIT);

    state_e      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    mem_wb_t     wb_d, wb_fwd;
    logic        addr_err_d, bus_err_d;
    logic        req_c, stall_c, op;
    logic [3:0]  byte_en;
    logic [31:0] wdata, load_data;
    logic        misaligned;

    mips_stage_mem_align u_align (
        .mem_read   (pipe_ex_mem.ctrl.mem_read),
        .mem_size   (pipe_ex_mem.ctrl.mem_size),
        .mem_signed (pipe_ex_mem.ctrl.mem_signed),
        .addr_lo    (pipe_ex_mem.alu_result[1:0]),
        .store_data (pipe_ex_mem.reg_port2),
        .load_raw   (mem_bus.mem_rdata),
        .byte_en    (byte_en),
        .wdata      (wdata),
        .load_data  (load_data),
        .misaligned (misaligned)
    );

    // Upstream is frozen while BUSY, so these stay stable for the whole access.
    assign mem_bus.mem_addr    = {pipe_ex_mem.alu_result[31:2], 2'b00};
    assign mem_bus.mem_write   = pipe_ex_mem.ctrl.mem_write;
    assign mem_bus.mem_byte_en = byte_en;
    assign mem_bus.mem_wdata   = wdata;

    // Reset must drop the request at once even though pipe_ex_mem may still hold an op.
    assign mem_bus.mem_req = req_c & rst_n;
    assign stall           = stall_c & rst_n;

    assign op = is_mem_op(pipe_ex_mem.ctrl.mem_read, pipe_ex_mem.ctrl.mem_write);

    always_comb begin
        wb_fwd             = MEM_WB_BUBBLE;
        wb_fwd.instruction = pipe_ex_mem.instruction;
        wb_fwd.pc_addr     = pipe_ex_mem.pc_addr;
        wb_fwd.ctrl        = pipe_ex_mem.ctrl;
        wb_fwd.alu_result  = pipe_ex_mem.alu_result;
        wb_fwd.mem_data    = load_data;
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        req_c      = 1'b0;
        stall_c    = 1'b0;
        wb_d       = MEM_WB_BUBBLE;
        addr_err_d = 1'b0;
        bus_err_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!op) begin
                    wb_d = wb_fwd;
                end else if (misaligned) begin
                    addr_err_d = 1'b1;
                end else begin
                    req_c = 1'b1;
                    if (mem_bus.mem_ready) begin
                        wb_d = wb_fwd;
                    end else begin
                        stall_c = 1'b1;
                        cnt_d   = 8'd1;
                        state_d = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (mem_bus.mem_ready) begin
                    req_c   = 1'b1;
                    wb_d    = wb_fwd;
                    cnt_d   = 8'd0;
                    state_d = ST_IDLE;
                end else if (cnt_q == LIMIT) begin
                    bus_err_d = 1'b1;
                    cnt_d     = 8'd0;
                    state_d   = ST_IDLE;
                end else begin
                    req_c   = 1'b1;
                    stall_c = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                end
            end
            default: begin
                cnt_d   = 8'd0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= 8'd0;
            addr_error <= 1'b0;
            bus_error  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_error <= addr_err_d;
            bus_error  <= bus_err_d;
        end
    end

    generate
        if (DELAYED) begin : g_wb_reg
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    pipe_mem_wb <= MEM_WB_BUBBLE;
                end else begin
                    pipe_mem_wb <= wb_d;
                end
            end
        end else begin : g_wb_comb
            assign pipe_mem_wb = wb_d;
        end
    endgenerate

endmodule

// File: tb/tb_mips_stage_mem.sv
// Scoreboard bench for mips_stage_mem: random and directed accesses against a
// behavioural memory-stage model; a monitor checks every MEM->WB cycle.
module tb_mips_stage_mem;
    import mips_stage_mem_pkg::*;

    localparam int LIMIT = 4;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    ex_mem_t pipe_ex_mem;
    mem_wb_t pipe_mem_wb;
    logic    stall, addr_error, bus_error;

    always #5 clk = ~clk;

    mips_stage_mem_if mbus ();

    mips_stage_mem #(.DELAYED(1'b1), .WAIT_LIMIT(LIMIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pipe_ex_mem (pipe_ex_mem),
        .pipe_mem_wb (pipe_mem_wb),
        .stall       (stall),
        .addr_error  (addr_error),
        .bus_error   (bus_error),
        .mem_bus     (mbus.master)
    );

    typedef struct {
        mem_wb_t wb;
        logic    aerr;
        logic    berr;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Reference model: what a MIPS memory stage must do, stated arithmetically.
    function automatic bit f_misaligned(input ex_mem_t ex);
        int a = int'(ex.alu_result % 4);
        if (ex.ctrl.mem_size == MEM_HALF) return (a % 2) != 0;
        if (ex.ctrl.mem_size == MEM_WORD) return a != 0;
        return 1'b0;
    endfunction

    function automatic logic [31:0] f_load(input ex_mem_t ex, input logic [31:0] rdata);
        logic [31:0] v;
        int a = int'(ex.alu_result % 4);
        if (!ex.ctrl.mem_read) return 32'd0;
        case (ex.ctrl.mem_size)
            MEM_BYTE: begin
                v = (rdata >> (8 * a)) & 32'hFF;
                if (ex.ctrl.mem_signed && v >= 32'h80) v = v | 32'hFFFF_FF00;
            end
            MEM_HALF: begin
                v = (rdata >> (8 * a)) & 32'hFFFF;
                if (ex.ctrl.mem_signed && v >= 32'h8000) v = v | 32'hFFFF_0000;
            end
            default: v = rdata;
        endcase
        return v;
    endfunction

    function automatic logic [3:0] f_byte_en(input ex_mem_t ex);
        int a = int'(ex.alu_result % 4);
        if (ex.ctrl.mem_size == MEM_BYTE) return 4'(1 << a);
        if (ex.ctrl.mem_size == MEM_HALF) return 4'(3 << a);
        return 4'hF;
    endfunction

    function automatic logic [31:0] f_wdata(input ex_mem_t ex);
        if (ex.ctrl.mem_size == MEM_BYTE) return (ex.reg_port2 & 32'hFF) * 32'h0101_0101;
        if (ex.ctrl.mem_size == MEM_HALF) return (ex.reg_port2 & 32'hFFFF) * 32'h0001_0001;
        return ex.reg_port2;
    endfunction

    function automatic ex_mem_t mk(input bit rd, input bit wr, input mem_size_e sz,
                                   input bit sgn, input logic [31:0] addr,
                                   input logic [31:0] data);
        ex_mem_t ex;
        ex.instruction     = $urandom;
        ex.pc_addr         = $urandom & 32'hFFFF_FFFC;
        ex.ctrl.reg_write  = rd;
        ex.ctrl.mem_to_reg = rd;
        ex.ctrl.mem_read   = rd;
        ex.ctrl.mem_write  = wr;
        ex.ctrl.mem_size   = sz;
        ex.ctrl.mem_signed = sgn;
        ex.reg_port2       = data;
        ex.alu_result      = addr;
        return ex;
    endfunction

    task automatic push(input mem_wb_t wb, input logic aerr, input logic berr);
        exp_t e;
        e.wb   = wb;
        e.aerr = aerr;
        e.berr = berr;
        exp_q.push_back(e);
    endtask

    // Present one EX/MEM bundle for as long as the stage holds it; memory answers after 'waits' cycles.
    task automatic run_tx(input ex_mem_t ex, input int waits, input logic [31:0] rdata);
        bit      op   = ex.ctrl.mem_read || ex.ctrl.mem_write;
        bit      mis  = op && f_misaligned(ex);
        bit      acc  = op && !mis;
        bit      tout = acc && (waits > LIMIT);
        int      nstall = !acc ? 0 : (tout ? LIMIT : waits);
        bit      rdy, exp_req;
        mem_wb_t res;
        res.instruction = ex.instruction;
        res.pc_addr     = ex.pc_addr;
        res.ctrl        = ex.ctrl;
        res.alu_result  = ex.alu_result;
        res.mem_data    = f_load(ex, rdata);

        @(negedge clk);
        for (int i = 0; i < nstall; i++) push(MEM_WB_BUBBLE, 1'b0, 1'b0);
        if (mis)       push(MEM_WB_BUBBLE, 1'b1, 1'b0);
        else if (tout) push(MEM_WB_BUBBLE, 1'b0, 1'b1);
        else           push(res, 1'b0, 1'b0);

        for (int c = 0; c <= nstall; c++) begin
            if (c > 0) @(negedge clk);
            pipe_ex_mem    = ex;
            rdy            = acc && (c >= waits);
            mbus.mem_ready = acc ? rdy : 1'($urandom);
            mbus.mem_rdata = rdy ? rdata : $urandom;
            #1;
            exp_req = acc && ((c < nstall) || !tout);
            chk("stall", 256'(stall), 256'(c < nstall));
            chk("mem_req", 256'(mbus.mem_req), 256'(exp_req));
            if (exp_req) begin
                chk("mem_addr", 256'(mbus.mem_addr), 256'(ex.alu_result & 32'hFFFF_FFFC));
                chk("mem_byte_en", 256'(mbus.mem_byte_en), 256'(f_byte_en(ex)));
                chk("mem_write", 256'(mbus.mem_write), 256'(ex.ctrl.mem_write));
                if (ex.ctrl.mem_write) chk("mem_wdata", 256'(mbus.mem_wdata), 256'(f_wdata(ex)));
            end
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst_n && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("wb_bundle", 256'(pipe_mem_wb), 256'(e.wb));
            chk("addr_error", 256'(addr_error), 256'(e.aerr));
            chk("bus_error", 256'(bus_error), 256'(e.berr));
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "simulation time budget exhausted");
    end

    initial begin
        ex_mem_t ex;
        mem_size_e sz;
        logic [31:0] addr;
        pipe_ex_mem    = '0;
        mbus.mem_ready = 1'b0;
        mbus.mem_rdata = '0;

        repeat (2) @(negedge clk);
        pipe_ex_mem = mk(1, 0, MEM_WORD, 0, 32'h100, 0);
        #1;
        chk("reset_wb", 256'(pipe_mem_wb), 256'(0));
        chk("reset_stall", 256'(stall), 256'(0));
        chk("reset_mem_req", 256'(mbus.mem_req), 256'(0));
        chk("reset_addr_error", 256'(addr_error), 256'(0));
        chk("reset_bus_error", 256'(bus_error), 256'(0));
        @(negedge clk);
        pipe_ex_mem = '0;
        rst_n = 1'b1;

        run_tx(mk(1, 0, MEM_WORD, 0, 32'h100, 0), 0, 32'hDEAD_BEEF);
        run_tx(mk(1, 0, MEM_BYTE, 1, 32'h103, 0), 3, 32'h80FF_FFFF);
        run_tx(mk(1, 0, MEM_BYTE, 0, 32'h103, 0), 3, 32'h80FF_FFFF);
        run_tx(mk(0, 1, MEM_HALF, 0, 32'h202, 32'h1234_ABCD), 0, 32'h0);
        run_tx(mk(1, 0, MEM_WORD, 0, 32'h101, 0), 0, 32'h0);
        run_tx(mk(1, 0, MEM_WORD, 0, 32'h300, 0), 100, 32'h0);
        run_tx(mk(1, 0, MEM_HALF, 1, 32'h302, 0), LIMIT, 32'h8001_7FFF);
        run_tx('0, 0, 32'h0);

        // Reset during the second wait cycle of an outstanding load.
        ex = mk(1, 0, MEM_WORD, 0, 32'h400, 0);
        @(negedge clk);
        push(MEM_WB_BUBBLE, 1'b0, 1'b0);
        push(MEM_WB_BUBBLE, 1'b0, 1'b0);
        pipe_ex_mem    = ex;
        mbus.mem_ready = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("busy_stall", 256'(stall), 256'(1));
        rst_n = 1'b0;
        #1;
        chk("midreset_mem_req", 256'(mbus.mem_req), 256'(0));
        chk("midreset_stall", 256'(stall), 256'(0));
        chk("midreset_wb", 256'(pipe_mem_wb), 256'(0));
        exp_q.delete();
        repeat (2) @(negedge clk);
        pipe_ex_mem = '0;
        rst_n = 1'b1;
        run_tx(mk(1, 0, MEM_WORD, 0, 32'h400, 0), 1, 32'hCAFE_F00D);

        for (int n = 0; n < 200; n++) begin
            int kind = $urandom_range(0, 9);
            if (kind < 2) begin
                run_tx('0, 0, 32'h0);
            end else if (kind == 2) begin
                ex = mk(0, 0, MEM_BYTE, 0, $urandom, $urandom);
                ex.ctrl.reg_write = 1'b1;
                run_tx(ex, 0, $urandom);
            end else begin
                sz   = mem_size_e'($urandom_range(0, 2));
                addr = $urandom;
                if ($urandom_range(0, 3) != 0) begin
                    if (sz == MEM_HALF) addr[0] = 1'b0;
                    if (sz == MEM_WORD) addr[1:0] = 2'b00;
                end
                if ($urandom_range(0, 1) == 1)
                    ex = mk(1, 0, sz, 1'($urandom), addr, $urandom);
                else
                    ex = mk(0, 1, sz, 1'b0, addr, $urandom);
                run_tx(ex, $urandom_range(0, 6), $urandom);
            end
        end

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        chk("scoreboard_drained", 256'(exp_q.size()), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
